// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl
//
// Built-in self test sequencer for a simple dual-port RAM. A test runs in
// three phases:
//   1. Write every word with a selectable data pattern.
//   2. Read every word back.
//   3. Drain the RAM read pipeline.
// The controller then compares each returned word against the pattern it
// wrote. It reports a pass flag, a saturating mismatch count, and the address
// and data of the first mismatch.
//
// Ports
//   clk, rst          clock and asynchronous active-high reset
//   start             one-cycle test request (accepted only in IDLE or DONE)
//   pattern_sel       data pattern, latched when start is accepted
//   busy              high while a test runs (WRITE, READ, DRAIN)
//   done, pass        test finished / finished with no mismatches
//   fail_count        saturating mismatch count
//   first_fail_addr   address of the first mismatching word
//   first_fail_data   data read at the first mismatch
//   addra/wena/dina   RAM write port
//   addrb/renb        RAM read port; renb also advances the RAM read pipeline
//   doutb             RAM read data, RD_LATENCY cycles after the address
module ram_bist_ctrl #(
  parameter  int DATA_WIDTH = 32,
  parameter  int MEM_DEPTH  = 1024,
  parameter  int RD_LATENCY = 3,
  localparam int ADDR_WIDTH = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            pattern_sel,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           fail_count,
  output logic [ADDR_WIDTH-1:0] first_fail_addr,
  output logic [DATA_WIDTH-1:0] first_fail_data,
  output logic [ADDR_WIDTH-1:0] addra,
  output logic                  wena,
  output logic [DATA_WIDTH-1:0] dina,
  output logic [ADDR_WIDTH-1:0] addrb,
  output logic                  renb,
  input  logic [DATA_WIDTH-1:0] doutb
);

  localparam int DRAIN_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [DRAIN_W-1:0]    DRAIN_LAST = DRAIN_W'(RD_LATENCY - 1);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DRAIN_W-1:0]      drain_q, drain_d;
  logic [1:0]              sel_q, sel_d;
  logic [RD_LATENCY-1:0]   pipe_vld_q, pipe_vld_d;
  logic [ADDR_WIDTH-1:0]   pipe_addr_q [RD_LATENCY];
  logic [ADDR_WIDTH-1:0]   pipe_addr_d [RD_LATENCY];
  logic [15:0]             fail_count_q, fail_count_d;
  logic [ADDR_WIDTH-1:0]   ffa_q, ffa_d;
  logic [DATA_WIDTH-1:0]   ffd_q, ffd_d;
  logic                    start_accept;
  logic                    rd_active;

  // Pattern for a given address.
  // Pattern 2 zero-extends or truncates the address to DATA_WIDTH. To
  // handle both cases, the address is padded with zeros before slicing.
  function automatic logic [DATA_WIDTH-1:0] pattern_word(
    input logic [ADDR_WIDTH-1:0] a,
    input logic [1:0]            sel
  );
    logic [DATA_WIDTH+ADDR_WIDTH-1:0] ext;
    logic [DATA_WIDTH-1:0]            word;
    ext  = {{DATA_WIDTH{1'b0}}, a};
    word = '0;
    case (sel)
      2'd0:    word = '0;
      2'd1:    word = '1;
      2'd2:    word = ext[DATA_WIDTH-1:0];
      default: begin
        // 0x5 nibbles set the even bits; 0xA nibbles set the odd bits.
        for (int i = 0; i < DATA_WIDTH; i++) begin
          word[i] = a[0] ? (i % 2 == 1) : (i % 2 == 0);
        end
      end
    endcase
    return word;
  endfunction

  assign start_accept = start && ((state_q == IDLE) || (state_q == DONE));
  assign rd_active    = (state_q == READ) || (state_q == DRAIN);

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      drain_q      <= '0;
      sel_q        <= '0;
      pipe_vld_q   <= '0;
      for (int i = 0; i < RD_LATENCY; i++) pipe_addr_q[i] <= '0;
      fail_count_q <= '0;
      ffa_q        <= '0;
      ffd_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      drain_q      <= drain_d;
      sel_q        <= sel_d;
      pipe_vld_q   <= pipe_vld_d;
      pipe_addr_q  <= pipe_addr_d;
      fail_count_q <= fail_count_d;
      ffa_q        <= ffa_d;
      ffd_q        <= ffd_d;
    end
  end

  // Next-state logic.
  // cnt_q is the phase address, which is reused by WRITE and READ.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = WRITE;
          cnt_d   = '0;
          sel_d   = pattern_sel;
        end
      end
      WRITE: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = READ;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      READ: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = DRAIN;
          cnt_d   = '0;
          drain_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = DONE;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Compare pipeline and result tracking.
  // The pipeline shifts only while renb is high, so that it stays in step
  // with the RAM. The tail entry lines up with the word on doutb. The count
  // saturates and never returns to zero within a run, so a zero count means
  // no mismatch has been seen yet.
  always_comb begin
    pipe_vld_d   = pipe_vld_q;
    pipe_addr_d  = pipe_addr_q;
    fail_count_d = fail_count_q;
    ffa_d        = ffa_q;
    ffd_d        = ffd_q;
    if (rd_active) begin
      for (int i = RD_LATENCY - 1; i > 0; i--) begin
        pipe_vld_d[i]  = pipe_vld_q[i-1];
        pipe_addr_d[i] = pipe_addr_q[i-1];
      end
      pipe_vld_d[0]  = (state_q == READ);
      pipe_addr_d[0] = cnt_q;
      if (pipe_vld_q[RD_LATENCY-1] &&
          (doutb != pattern_word(pipe_addr_q[RD_LATENCY-1], sel_q))) begin
        if (fail_count_q == 16'd0) begin
          ffa_d = pipe_addr_q[RD_LATENCY-1];
          ffd_d = doutb;
        end
        if (fail_count_q != 16'hFFFF) begin
          fail_count_d = fail_count_q + 16'd1;
        end
      end
    end
    if (start_accept) begin
      fail_count_d = '0;
      ffa_d        = '0;
      ffd_d        = '0;
      pipe_vld_d   = '0;
    end
  end

  // Outputs are decoded from state. As a result, they all fall to zero as
  // soon as reset forces IDLE.
  always_comb begin
    busy  = (state_q == WRITE) || (state_q == READ) || (state_q == DRAIN);
    done  = (state_q == DONE);
    pass  = (state_q == DONE) && (fail_count_q == 16'd0);
    wena  = (state_q == WRITE);
    addra = '0;
    dina  = '0;
    renb  = rd_active;
    addrb = '0;
    if (state_q == WRITE) begin
      addra = cnt_q;
      dina  = pattern_word(cnt_q, sel_q);
    end
    if (state_q == READ) begin
      addrb = cnt_q;
    end else if (state_q == DRAIN) begin
      addrb = LAST_ADDR;
    end
  end

  assign fail_count      = fail_count_q;
  assign first_fail_addr = ffa_q;
  assign first_fail_data = ffd_q;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// tb_ram_bist_ctrl
//
// Self-checking bench for ram_bist_ctrl. The DUT is configured with 16 words,
// a read latency of 3 and 32-bit data. A behavioural RAM model supplies
// doutb, and it can inject faults:
//   - a corrupted word at address 5
//   - bit 0 stuck at 1 on every word
// A table of runs covers patterns and faults. Hand-written sequences cover
// start during a run, restart from DONE, and reset during the write phase.
module tb_ram_bist_ctrl;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int LAT   = 3;
  localparam int AW    = 4;
  localparam int BUSY_CYCLES = 2 * DEPTH + LAT;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    pattern_sel = 2'd0;
  logic          busy, done, pass, wena, renb;
  logic [15:0]   fail_count;
  logic [AW-1:0] first_fail_addr, addra, addrb;
  logic [DW-1:0] first_fail_data, dina, doutb;

  int checks   = 0;
  int failures = 0;

  // 0: clean RAM, 1: address 5 reads 0xDEAD0000, 2: bit 0 stuck at 1
  int fault_mode = 0;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_pipe [LAT];

  typedef struct {
    logic [1:0]  sel;
    int          fault;
    logic        exp_pass;
    int          exp_fc;
    int          exp_ffa;
    logic [31:0] exp_ffd;
  } vec_t;

  localparam int NV = 6;
  vec_t vecs [NV];

  ram_bist_ctrl #(
    .DATA_WIDTH(DW),
    .MEM_DEPTH (DEPTH),
    .RD_LATENCY(LAT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .pattern_sel    (pattern_sel),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .fail_count     (fail_count),
    .first_fail_addr(first_fail_addr),
    .first_fail_data(first_fail_data),
    .addra          (addra),
    .wena           (wena),
    .dina           (dina),
    .addrb          (addrb),
    .renb           (renb),
    .doutb          (doutb)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] read_word(input logic [AW-1:0] a);
    if (fault_mode == 1 && a == 4'd5) return 32'hDEAD0000;
    if (fault_mode == 2) return mem[a] | 32'h1;
    return mem[a];
  endfunction

  // Behavioural RAM
  // The model has one write port and a LAT-stage read pipeline that
  // advances only while renb is high.
  always @(posedge clk) begin
    if (wena) mem[addra] <= dina;
    if (renb) begin
      rd_pipe[0] <= read_word(addrb);
      for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end
  assign doutb = rd_pipe[LAT-1];

  function automatic logic [DW-1:0] tb_pattern(input logic [AW-1:0] a, input logic [1:0] sel);
    case (sel)
      2'd0:    return 32'h00000000;
      2'd1:    return 32'hFFFFFFFF;
      2'd2:    return {28'd0, a};
      default: return a[0] ? 32'hAAAAAAAA : 32'h55555555;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Pulses start with sel, then flips pattern_sel mid-run to confirm it is
  // latched. The task counts busy cycles and writes. A write counts as bad
  // if it goes to an unexpected address or carries an unexpected word.
  task automatic applyStimulus(input logic [1:0] sel, output int busy_n,
                               output int wr_n, output int bad_n);
    busy_n = 0;
    wr_n   = 0;
    bad_n  = 0;
    @(negedge clk);
    start       = 1'b1;
    pattern_sel = sel;
    @(negedge clk);
    start       = 1'b0;
    pattern_sel = ~sel;
    while (busy && busy_n < 200) begin
      busy_n++;
      if (wena) begin
        if (addra != AW'(wr_n) || dina != tb_pattern(addra, sel)) bad_n++;
        wr_n++;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int busy_n, wr_n, bad_n, cyc, seen;

    // Odd words of pattern 3 (0xA...) have bit 0 clear, so those words fail
    // under a stuck-at-1 bit 0. Pattern 0 fails on every word.
    vecs[0] = '{2'd2, 0, 1'b1, 0,  0, 32'h00000000};
    vecs[1] = '{2'd0, 1, 1'b0, 1,  5, 32'hDEAD0000};
    vecs[2] = '{2'd3, 2, 1'b0, 8,  1, 32'hAAAAAAAB};
    vecs[3] = '{2'd1, 0, 1'b1, 0,  0, 32'h00000000};
    vecs[4] = '{2'd3, 0, 1'b1, 0,  0, 32'h00000000};
    vecs[5] = '{2'd0, 2, 1'b0, 16, 0, 32'h00000001};

    repeat (2) @(negedge clk);
    checkOutput("reset_flags", {27'd0, busy, done, pass, wena, renb}, 32'd0);
    checkOutput("reset_fail_count", fail_count, 32'd0);
    checkOutput("reset_addr", {addra, addrb}, 32'd0);
    checkOutput("reset_dina", dina, 32'd0);
    rst = 1'b0;

    for (int v = 0; v < NV; v++) begin
      fault_mode = vecs[v].fault;
      applyStimulus(vecs[v].sel, busy_n, wr_n, bad_n);
      checkOutput($sformatf("v%0d_busy_cycles", v), busy_n, BUSY_CYCLES);
      checkOutput($sformatf("v%0d_writes", v), wr_n, DEPTH);
      checkOutput($sformatf("v%0d_bad_writes", v), bad_n, 0);
      checkOutput($sformatf("v%0d_done", v), done, 1);
      checkOutput($sformatf("v%0d_pass", v), pass, vecs[v].exp_pass);
      checkOutput($sformatf("v%0d_fail_count", v), fail_count, vecs[v].exp_fc);
      checkOutput($sformatf("v%0d_first_fail_addr", v), first_fail_addr, vecs[v].exp_ffa);
      checkOutput($sformatf("v%0d_first_fail_data", v), first_fail_data, vecs[v].exp_ffd);
    end

    // Restart from DONE after a failing run clears the results at once. A
    // start pulsed during READ (with a different pattern) is ignored.
    fault_mode = 0;
    @(negedge clk);
    start       = 1'b1;
    pattern_sel = 2'd1;
    @(negedge clk);
    start       = 1'b0;
    checkOutput("restart_done_clear", done, 0);
    checkOutput("restart_pass_clear", pass, 0);
    checkOutput("restart_fc_clear", fail_count, 0);
    checkOutput("restart_ffa_clear", first_fail_addr, 0);
    checkOutput("restart_ffd_clear", first_fail_data, 0);
    checkOutput("restart_busy", busy, 1);
    cyc = 0;
    while (busy && cyc < 200) begin
      cyc++;
      if (cyc == DEPTH + 4) begin
        checkOutput("start_in_read_phase", {30'd0, wena, renb}, 32'd1);
        start       = 1'b1;
        pattern_sel = 2'd0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    checkOutput("ignored_start_busy_cycles", cyc, BUSY_CYCLES);
    checkOutput("ignored_start_done", done, 1);
    checkOutput("ignored_start_pass", pass, 1);
    checkOutput("ignored_start_fc", fail_count, 0);

    // Reset asserted during write cycle 7 aborts the run immediately.
    @(negedge clk);
    start       = 1'b1;
    pattern_sel = 2'd2;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(wena && addra == 4'd7) && cyc < 50) begin
      cyc++;
      @(negedge clk);
    end
    checkOutput("reached_write7", addra, 7);
    #1 rst = 1'b1;
    #1;
    checkOutput("abort_wena", wena, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_renb_done", {30'd0, renb, done}, 0);
    checkOutput("abort_addra_dina", {28'd0, addra} | dina, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (3 * DEPTH) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    checkOutput("abort_no_done", seen, 0);
    applyStimulus(2'd2, busy_n, wr_n, bad_n);
    checkOutput("post_abort_busy_cycles", busy_n, BUSY_CYCLES);
    checkOutput("post_abort_writes", wr_n, DEPTH);
    checkOutput("post_abort_bad_writes", bad_n, 0);
    checkOutput("post_abort_done", done, 1);
    checkOutput("post_abort_pass", pass, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
